// File: rtl/node_pkg.sv
// node_pkg: shared types and constants for the node receive path.
package node_pkg;

    localparam int FLIT_WIDTH      = 32;
    localparam int NODE_FIFO_DEPTH = 4;

    typedef logic [FLIT_WIDTH-1:0] flit_t;

endpackage : node_pkg

// File: rtl/node_fifo_mem.sv
// node_fifo_mem: DEPTH x FLIT_W register array, one synchronous write port,
// one asynchronous read port. Holds payload only; no control state.
module node_fifo_mem
    import node_pkg::*;
#(
    parameter int FLIT_W = FLIT_WIDTH,
    parameter int DEPTH  = NODE_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [FLIT_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [FLIT_W-1:0]        rdata
);

    logic [FLIT_W-1:0] mem [DEPTH];

    // Write the addressed entry on an accepted flit.
    // NOTE: storage is deliberately left out of reset; validity is tracked by
    // the pointers/count, so stale entries are never consumed.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Head-of-queue read is combinational so the FIFO falls through.
    assign rdata = mem[raddr];

endmodule : node_fifo_mem

// File: rtl/node_input_fifo.sv
// node_input_fifo: first-word-fall-through receive buffer between a link and
// the router stage, flit/enable/ack handshake on both sides. in_ack and
// out_enable come from registered occupancy only, so there is no
// combinational path from out_ack to in_ack.
// Optional build macro NODE_FIFO_WATERMARK_EN adds high_water and
// overflow_seen status outputs.
module node_input_fifo
    import node_pkg::*;
#(
    parameter int FLIT_W = FLIT_WIDTH,
    parameter int DEPTH  = NODE_FIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [FLIT_W-1:0]          in_flit,
    input  logic                       in_enable,
    output logic                       in_ack,
    output logic [FLIT_W-1:0]          out_flit,
    output logic                       out_enable,
    input  logic                       out_ack,
`ifdef NODE_FIFO_WATERMARK_EN
    output logic [$clog2(DEPTH+1)-1:0] high_water,
    output logic                       overflow_seen,
`endif
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    // Handshake flags derive purely from registered occupancy.
    assign in_ack     = (count != FULL);
    assign out_enable = (count != '0);
    assign push       = in_enable & in_ack;
    assign pop        = out_enable & out_ack;

    node_fifo_mem #(
        .FLIT_W (FLIT_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (in_flit),
        .raddr (rd_ptr),
        .rdata (out_flit)
    );

    // Advance pointers and track occupancy; a push and pop together cancel.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef NODE_FIFO_WATERMARK_EN
    // Peak occupancy since reset, and a sticky flag for a stalled link.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            high_water    <= '0;
            overflow_seen <= 1'b0;
        end else begin
            if (count > high_water) begin
                high_water <= count;
            end
            if (in_enable && (count == FULL)) begin
                overflow_seen <= 1'b1;
            end
        end
    end
`endif

endmodule : node_input_fifo

// File: doc/node_input_fifo.md
Name: node_input_fifo

Overview:
- Receive-side buffer placed directly downstream of a node-to-node link. Absorbs the link's flit/enable stream into a small FIFO and returns ack.
- Presents buffered flits to the node's routing/crossbar stage with the same flit/enable/ack handshake.
- Decouples link backpressure from router arbitration timing. No combinational path from out_ack to in_ack.

Parameters:
- FLIT_W, 32, flit width in bits; must equal the package flit width.
- DEPTH, 4, number of flit entries; power of two, at least 2.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_flit  input  FLIT_W  flit from the link.
- in_enable  input  1  link presents a valid flit.
- in_ack  output  1  FIFO accepts in_flit this cycle.
- out_flit  output  FLIT_W  head-of-queue flit to the router.
- out_enable  output  1  out_flit is valid.
- out_ack  input  1  router consumes out_flit this cycle.
- count  output  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Handshake on both sides: a transfer occurs on a rising edge where enable and ack are both 1. The sender holds flit stable while enable=1 and ack=0. ack may be high while enable=0; that is not a transfer.
- in_ack = (count != DEPTH). Derived only from registered state.
- out_enable = (count != 0).
- out_flit = mem[rd_ptr], first-word-fall-through. When out_enable=0, out_flit shows the stale entry; the consumer ignores it.
- push = in_enable & in_ack. On push: mem[wr_ptr] <= in_flit, wr_ptr++.
- pop = out_enable & out_ack. On pop: rd_ptr++.
- count next value:
  - push only: +1
  - pop only: -1
  - both or neither: unchanged.
- Pointers have width $clog2(DEPTH) and wrap naturally from DEPTH-1 to 0.
- Latency: a flit accepted at edge N appears on out_enable/out_flit after edge N. There is no empty-bypass path, so there is 1 cycle minimum through the block.
- Full (count=DEPTH):
  - in_ack=0, so no push.
  - A pop in the same cycle frees a slot; in_ack rises the following cycle, not combinationally.
- Empty (count=0):
  - out_enable=0, so out_ack is ignored and no pop occurs.
  - A same-cycle push makes out_enable=1 the next cycle.
- Simultaneous push and pop at 0<count<DEPTH: both take effect and count holds.
- Reset values (asynchronous, immediate on rst=1, including mid-transfer):
  - rd_ptr=0, wr_ptr=0, count=0
  - in_ack=1 (reflects empty)
  - out_enable=0
  - Any in-flight flits are discarded.
  - mem contents are not reset.
- A transfer presented in the cycle rst deasserts is accepted normally.
- Flit contents are opaque and never inspected or modified.

Optional Feature:
- Macro: NODE_FIFO_WATERMARK_EN.
- When defined:
  - Adds output high_water (width $clog2(DEPTH+1)) holding the peak count since reset. It updates the cycle after a new maximum is reached.
  - Adds output overflow_seen (1 bit), a sticky flag set when in_enable=1 while count=DEPTH (link stalled by this buffer).
  - Both clear only on rst and reset to 0.
- When undefined: neither port nor its logic exists; all other behaviour is identical.

Decomposition:
- Shared package node_pkg holds:
  - flit width constant FLIT_WIDTH
  - flit_t typedef
  - default buffer depth constant NODE_FIFO_DEPTH
- Optional sub-module node_fifo_mem: DEPTH x FLIT_W register array with one write port and one asynchronous read port. Pointer, count and handshake logic stay in node_input_fifo.

Test Plan:
- Reset then idle: rst pulse mid-sim with 2 flits queued -> count=0, out_enable=0 and in_ack=1 immediately, before the next clk edge.
- Single flit: push 0xDEADBEEF at edge N -> out_enable=1 and out_flit=0xDEADBEEF after edge N. out_ack=1 -> count returns to 0.
- Fill to full, DEPTH=4, out_ack=0:
  - push 0x1..0x4 -> count=4, in_ack=0.
  - hold in_enable with 0x5 -> not accepted.
  - one pop -> in_ack=1 the next cycle; 0x5 enters; output order 0x1,0x2,0x3,0x4,0x5.
- Streaming: in_enable=out_ack=1 continuously for 20 flits with incrementing values -> count steady at 1, no drop or duplicate, order preserved, pointers wrap at least 4 times.
- Random stall: random in_enable/out_ack at 50%, 1000 cycles -> scoreboard matches exactly, count never exceeds 4, and no transfer occurs with enable=0.
- With NODE_FIFO_WATERMARK_EN: fill to 3 and drain -> high_water=3. Fill to 4 and hold in_enable -> overflow_seen=1 and stays set until rst.
